// File: rtl/qoi_stream_framer_if.sv
// Handshake and control bundle for qoi_stream_framer: start/config, encoder byte
// input stream, framed byte output stream and status.
interface qoi_stream_framer_if;
    logic        start;
    logic [31:0] img_width;
    logic [31:0] img_height;
    logic        colorspace;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic [31:0] frame_bytes;

    modport slave (
        input  start, img_width, img_height, colorspace,
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, busy, frame_bytes
    );

    modport master (
        output start, img_width, img_height, colorspace,
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy, frame_bytes
    );
endinterface

// File: rtl/qoi_stream_framer.sv
// Wraps an encoded QOI chunk stream with the 14-byte header and 8-byte end marker.
// Optional QOI_FRAMER_COUNT_EN adds the frame_bytes transfer counter.
//
// state   | meaning
// IDLE    | waiting for start; output register empty
// HEADER  | loading header bytes 0..13 into the output register
// BODY    | passing encoder bytes through until in_last is accepted
// TRAILER | loading 7 x 0x00 then 0x01; idx 8 waits for the final transfer
module qoi_stream_framer #(
    parameter int COMPONENTS = 4
) (
    input  logic             clk,
    input  logic             rst,
    qoi_stream_framer_if.slave s
);

    typedef enum logic [1:0] {IDLE, HEADER, BODY, TRAILER} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] width_q, width_d;
    logic [31:0] height_q, height_d;
    logic        cs_q, cs_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;

    logic        xfer;
    logic        out_free;
    logic        in_ready_c;
    logic [7:0]  hdr_byte;

    assign xfer     = out_valid_q && s.out_ready;
    assign out_free = !out_valid_q || s.out_ready;

    always_comb begin
        hdr_byte = 8'h00;
        case (idx_q)
            4'd0:    hdr_byte = 8'h71;
            4'd1:    hdr_byte = 8'h6F;
            4'd2:    hdr_byte = 8'h69;
            4'd3:    hdr_byte = 8'h66;
            4'd4:    hdr_byte = width_q[31:24];
            4'd5:    hdr_byte = width_q[23:16];
            4'd6:    hdr_byte = width_q[15:8];
            4'd7:    hdr_byte = width_q[7:0];
            4'd8:    hdr_byte = height_q[31:24];
            4'd9:    hdr_byte = height_q[23:16];
            4'd10:   hdr_byte = height_q[15:8];
            4'd11:   hdr_byte = height_q[7:0];
            4'd12:   hdr_byte = 8'(COMPONENTS);
            4'd13:   hdr_byte = {7'b0, cs_q};
            default: hdr_byte = 8'h00;
        endcase
    end

    // A new byte is loaded only when the register is empty or draining this cycle,
    // so the index steps exactly once per transferred byte.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        width_d     = width_q;
        height_d    = height_q;
        cs_d        = cs_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        in_ready_c  = 1'b0;

        if (xfer) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (s.start) begin
                    state_d  = HEADER;
                    idx_d    = 4'd0;
                    width_d  = s.img_width;
                    height_d = s.img_height;
                    cs_d     = s.colorspace;
                end
            end
            HEADER: begin
                if (out_free) begin
                    out_data_d  = hdr_byte;
                    out_valid_d = 1'b1;
                    if (idx_q == 4'd13) begin
                        idx_d   = 4'd0;
                        state_d = BODY;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            BODY: begin
                in_ready_c = out_free;
                if (out_free && s.in_valid) begin
                    out_data_d  = s.in_data;
                    out_valid_d = 1'b1;
                    if (s.in_last) begin
                        idx_d   = 4'd0;
                        state_d = TRAILER;
                    end
                end
            end
            TRAILER: begin
                if (idx_q == 4'd8) begin
                    if (xfer) begin
                        idx_d   = 4'd0;
                        state_d = IDLE;
                    end
                end else if (out_free) begin
                    out_data_d  = (idx_q == 4'd7) ? 8'h01 : 8'h00;
                    out_valid_d = 1'b1;
                    out_last_d  = (idx_q == 4'd7);
                    idx_d       = idx_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 4'd0;
            width_q     <= 32'd0;
            height_q    <= 32'd0;
            cs_q        <= 1'b0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            width_q     <= width_d;
            height_q    <= height_d;
            cs_q        <= cs_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef QOI_FRAMER_COUNT_EN
    logic [31:0] frame_bytes_q, frame_bytes_d;

    always_comb begin
        frame_bytes_d = frame_bytes_q;
        if (state_q == IDLE && s.start) begin
            frame_bytes_d = 32'd0;
        end else if (xfer) begin
            frame_bytes_d = frame_bytes_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_bytes_q <= 32'd0;
        end else begin
            frame_bytes_q <= frame_bytes_d;
        end
    end

    assign s.frame_bytes = frame_bytes_q;
`else
    assign s.frame_bytes = 32'd0;
`endif

    assign s.in_ready  = in_ready_c;
    assign s.out_data  = out_data_q;
    assign s.out_valid = out_valid_q;
    assign s.out_last  = out_last_q;
    assign s.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_qoi_stream_framer.sv
// Scoreboard bench for qoi_stream_framer: a COMPONENTS=4 and a COMPONENTS=3 instance
// run in lockstep on shared stimulus, each checked against its own expected byte queue.
module tb_qoi_stream_framer;

    typedef struct {
        logic [7:0]  data;
        logic        last;
        logic [31:0] total;
    } exp_t;

`ifdef QOI_FRAMER_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    bit   rand_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t       exp_q[2][$];
    logic [7:0] body_q[$];
    logic [7:0] magic[4];

    qoi_stream_framer_if if4 ();
    qoi_stream_framer_if if3 ();

    qoi_stream_framer #(.COMPONENTS(4)) dut4 (.clk(clk), .rst(rst), .s(if4));
    qoi_stream_framer #(.COMPONENTS(3)) dut3 (.clk(clk), .rst(rst), .s(if3));

    assign if3.start      = if4.start;
    assign if3.img_width  = if4.img_width;
    assign if3.img_height = if4.img_height;
    assign if3.colorspace = if4.colorspace;
    assign if3.in_data    = if4.in_data;
    assign if3.in_valid   = if4.in_valid;
    assign if3.in_last    = if4.in_last;
    assign if3.out_ready  = if4.out_ready;

    logic [7:0]  od[2];
    logic        ov[2], ol[2], ir[2], bz[2];
    logic [31:0] fb[2];
    assign od[0] = if4.out_data;  assign od[1] = if3.out_data;
    assign ov[0] = if4.out_valid; assign ov[1] = if3.out_valid;
    assign ol[0] = if4.out_last;  assign ol[1] = if3.out_last;
    assign ir[0] = if4.in_ready;  assign ir[1] = if3.in_ready;
    assign bz[0] = if4.busy;      assign bz[1] = if3.busy;
    assign fb[0] = if4.frame_bytes; assign fb[1] = if3.frame_bytes;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if4.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference frame: magic, big-endian dimensions, channels, colorspace, body, end marker.
    task automatic push_frame(input logic [31:0] w, input logic [31:0] h, input logic cs);
        logic [7:0]  hdr[14];
        int          n;
        logic [31:0] total;
        n     = body_q.size();
        total = 32'(14 + n + 8);
        for (int k = 0; k < 4; k++) begin
            hdr[k]     = magic[k];
            hdr[4 + k] = 8'(w >> (24 - 8 * k));
            hdr[8 + k] = 8'(h >> (24 - 8 * k));
        end
        hdr[13] = {7'b0, cs};
        for (int d = 0; d < 2; d++) begin
            hdr[12] = (d == 0) ? 8'd4 : 8'd3;
            for (int k = 0; k < 14; k++) exp_q[d].push_back('{hdr[k], 1'b0, 32'd0});
            for (int k = 0; k < n; k++) exp_q[d].push_back('{body_q[k], 1'b0, 32'd0});
            for (int k = 0; k < 7; k++) exp_q[d].push_back('{8'h00, 1'b0, 32'd0});
            exp_q[d].push_back('{8'h01, 1'b1, total});
        end
    endtask

    task automatic fill_body(input int n);
        body_q.delete();
        for (int k = 0; k < n; k++) body_q.push_back(8'($urandom));
    endtask

    task automatic run_frame(input logic [31:0] w, input logic [31:0] h, input logic cs,
                             input bit full, input bit pulse);
        int n, i, t, start_cyc;
        bit pulsed;
        n = body_q.size();
        push_frame(w, h, cs);
        @(posedge clk); #1;
        if4.start = 1'b1; if4.img_width = w; if4.img_height = h; if4.colorspace = cs;
        @(negedge clk);
        start_cyc = cyc;
        i = 0; t = 0; pulsed = 1'b0;
        while (i < n && t < 3000) begin
            @(posedge clk); #1;
            if (pulse && !pulsed && i == n / 2) begin
                if4.start = 1'b1; if4.img_width = ~w; if4.img_height = ~h;
                if4.colorspace = ~cs; pulsed = 1'b1;
            end else begin
                if4.start = 1'b0;
            end
            if4.in_valid = full ? 1'b1 : ($urandom_range(0, 3) != 0);
            if4.in_data  = body_q[i];
            if4.in_last  = (i == n - 1);
            @(negedge clk);
            if (if4.in_valid && if4.in_ready) i++;
            t++;
        end
        if (i < n) chk("body_accept_timeout", 32'(i), 32'(n));
        @(posedge clk); #1;
        if4.start = 1'b0; if4.in_valid = 1'b0; if4.in_last = 1'b0;
        t = 0;
        while (t < 5000) begin
            @(negedge clk);
            if (if4.out_valid && if4.out_ready && if4.out_last) break;
            t++;
        end
        if (t >= 5000) chk("out_last_timeout", 32'(t), 32'd0);
        else if (full) chk("frame_latency", 32'(cyc - start_cyc), 32'(23 + n));
    endtask

    bit         stall[2];
    logic [7:0] prev_d[2];
    logic       prev_l[2];
    bit         pend[2];
    logic [31:0] pend_tot[2];

    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                stall[d] = 1'b0;
                pend[d]  = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                exp_t e;
                if (pend[d]) begin
                    chk($sformatf("busy_after_last[%0d]", d), 32'(bz[d]), 32'd0);
                    chk($sformatf("frame_bytes[%0d]", d), fb[d], CNT_EN ? pend_tot[d] : 32'd0);
                    pend[d] = 1'b0;
                end
                if (stall[d]) begin
                    chk($sformatf("hold_valid[%0d]", d), 32'(ov[d]), 32'd1);
                    chk($sformatf("hold_data[%0d]", d), 32'(od[d]), 32'(prev_d[d]));
                    chk($sformatf("hold_last[%0d]", d), 32'(ol[d]), 32'(prev_l[d]));
                end
                if (ov[d] && !if4.out_ready)
                    chk($sformatf("in_ready_stall[%0d]", d), 32'(ir[d]), 32'd0);
                stall[d]  = ov[d] && !if4.out_ready;
                prev_d[d] = od[d];
                prev_l[d] = ol[d];
                if (ov[d] && if4.out_ready) begin
                    if (exp_q[d].size() == 0) begin
                        chk($sformatf("unexpected_out[%0d]", d), 32'(od[d]), 32'hXXXX_XXXX);
                    end else begin
                        e = exp_q[d].pop_front();
                        chk($sformatf("out_data[%0d]", d), 32'(od[d]), 32'(e.data));
                        chk($sformatf("out_last[%0d]", d), 32'(ol[d]), 32'(e.last));
                        if (e.last) begin
                            chk($sformatf("busy_at_last[%0d]", d), 32'(bz[d]), 32'd1);
                            pend[d]     = 1'b1;
                            pend_tot[d] = e.total;
                        end
                    end
                end
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_out_valid[%0d]", tag, d), 32'(ov[d]), 32'd0);
            chk($sformatf("%s_out_last[%0d]", tag, d), 32'(ol[d]), 32'd0);
            chk($sformatf("%s_out_data[%0d]", tag, d), 32'(od[d]), 32'd0);
            chk($sformatf("%s_busy[%0d]", tag, d), 32'(bz[d]), 32'd0);
            chk($sformatf("%s_in_ready[%0d]", tag, d), 32'(ir[d]), 32'd0);
            chk($sformatf("%s_frame_bytes[%0d]", tag, d), fb[d], 32'd0);
        end
    endtask

    initial begin
        int cnt, t;
        magic[0] = 8'h71; magic[1] = 8'h6F; magic[2] = 8'h69; magic[3] = 8'h66;
        rst = 1'b1;
        if4.start = 1'b0; if4.img_width = 32'd0; if4.img_height = 32'd0;
        if4.colorspace = 1'b0; if4.in_data = 8'h00; if4.in_valid = 1'b0; if4.in_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_state("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 1x1 RGBA, single body byte offered from the start of the frame
        body_q.delete(); body_q.push_back(8'hFE);
        run_frame(32'd1, 32'd1, 1'b0, 1'b1, 1'b0);

        fill_body(20);
        run_frame(32'h1234_5678, 32'h0000_ABCD, 1'b1, 1'b1, 1'b0);

        rand_ready = 1'b1;
        fill_body(100);
        run_frame($urandom, $urandom, 1'($urandom), 1'b0, 1'b0);

        // start pulsed mid-body must not disturb the frame; next frame back-to-back
        fill_body(40);
        run_frame(32'd1000, 32'd77, 1'b0, 1'b0, 1'b1);
        fill_body(5);
        run_frame(32'd2000, 32'd88, 1'b1, 1'b0, 1'b0);

        fill_body(1);
        run_frame(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        rand_ready = 1'b0;
        fill_body(3);
        run_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);

        // reset while header byte 6 is presented
        fill_body(4);
        push_frame(32'hCAFE_0001, 32'd9, 1'b0);
        @(posedge clk); #1;
        if4.start = 1'b1; if4.img_width = 32'hCAFE_0001; if4.img_height = 32'd9;
        if4.colorspace = 1'b0;
        @(posedge clk); #1;
        if4.start = 1'b0;
        cnt = 0; t = 0;
        while (cnt < 6 && t < 100) begin
            @(negedge clk);
            if (if4.out_valid && if4.out_ready) cnt++;
            t++;
        end
        chk("bytes_before_reset", 32'(cnt), 32'd6);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q[0].delete(); exp_q[1].delete();
        #1;
        chk_reset_state("midframe_reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        if4.in_valid = 1'b1; if4.in_last = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("idle_after_reset_valid", 32'(if4.out_valid | if3.out_valid), 32'd0);
            chk("idle_after_reset_busy", 32'(if4.busy | if3.busy), 32'd0);
        end
        @(posedge clk); #1;
        if4.in_valid = 1'b0; if4.in_last = 1'b0;

        fill_body(6);
        run_frame(32'h0000_0102, 32'h0304_0506, 1'b1, 1'b1, 1'b0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("queue_empty[0]", 32'(exp_q[0].size()), 32'd0);
        chk("queue_empty[1]", 32'(exp_q[1].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d",
                 n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
